mic_ifu_prefetch: RTL and testbench

//  Instruction fetch unit for the MIC core: sequences the byte-wide fetch memory, keeps a

---
 rtl/mic_ifu_prefetch.sv | 144 ++++++++++++++
 tb/tb_mic_ifu_prefetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mic_ifu_prefetch.sv
// rtl/mic_ifu_prefetch.sv - MIC instruction fetch unit: byte prefetch queue feeding MBR1/MBR2
module mic_ifu_prefetch #(
    parameter int DEPTH = 6,
    parameter int AW    = 32
) (
    input  logic          clk_ifu,
    input  logic          reset_ifu_n,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_new,
    input  logic          consume1,
    input  logic          consume2,
    output logic [AW-1:0] mem_addr,
    output logic          mem_fetch,
    input  logic [7:0]    mem_data,
    output logic [7:0]    mbr1,
    output logic [15:0]   mbr2,
    output logic          mbr1_valid,
    output logic          mbr2_valid,
    output logic [AW-1:0] pc_out,
    output logic          ifu_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    logic [7:0]    queue [DEPTH];
    logic [IW-1:0] head;
    logic [CW-1:0] count;
    logic          inflight;
    logic          discard;
    logic [AW-1:0] imar;
    logic [AW-1:0] pc;
    logic [1:0]    state;
    logic [1:0]    state_next;

    logic          issue;
    logic          ret;
    logic          pop1;
    logic          pop2;
    logic          illegal;
    logic [CW-1:0] popped;
    logic [CW-1:0] count_next;
    logic [CW:0]   occupancy_next;
    logic [IW-1:0] tail_idx;
    logic [IW-1:0] head1_idx;

    // Circular index arithmetic that also works for non-power-of-two depths.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input logic [CW-1:0] off);
        logic [IW:0] sum;
        sum = {1'b0, base} + (IW+1)'(off);
        if (sum >= (IW+1)'(DEPTH)) begin
            sum = sum - (IW+1)'(DEPTH);
        end
        return sum[IW-1:0];
    endfunction

    assign issue     = reset_ifu_n && (state != ST_FULL) && !pc_load;
    assign mem_fetch = issue;
    assign mem_addr  = imar;
    assign ret       = inflight && !discard;
    assign tail_idx  = wrap_idx(head, count);
    assign head1_idx = wrap_idx(head, CW'(1));

    always_comb begin
        pop1    = 1'b0;
        pop2    = 1'b0;
        illegal = 1'b0;
        if (!pc_load) begin
            if (consume1 && consume2) begin
                illegal = 1'b1;
            end else if (consume1) begin
                if (count >= CW'(1)) pop1 = 1'b1;
                else                 illegal = 1'b1;
            end else if (consume2) begin
                if (count >= CW'(2)) pop2 = 1'b1;
                else                 illegal = 1'b1;
            end
        end
    end

    assign popped     = pop2 ? CW'(2) : (pop1 ? CW'(1) : CW'(0));
    assign count_next = pc_load ? CW'(0) : (count + CW'(ret) - popped);
    // FULL means every slot is either filled or reserved by the outstanding request.
    assign occupancy_next = (CW+1)'(count_next) + (CW+1)'(issue);

    always_comb begin
        state_next = ST_RUN;
        if (pc_load) begin
            state_next = ST_REDIR;
        end else if (occupancy_next >= (CW+1)'(DEPTH)) begin
            state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk_ifu or negedge reset_ifu_n) begin
        if (!reset_ifu_n) begin
            imar     <= '0;
            pc       <= '0;
            head     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            ifu_err  <= 1'b0;
            state    <= ST_RUN;
        end else begin
            inflight <= issue;
            discard  <= pc_load && inflight;
            count    <= count_next;
            state    <= state_next;
            if (illegal) begin
                ifu_err <= 1'b1;
            end
            if (pc_load) begin
                imar <= pc_new;
                pc   <= pc_new;
            end else begin
                if (issue) begin
                    imar <= imar + AW'(1);
                end
                pc   <= pc + AW'(popped);
                head <= wrap_idx(head, popped);
            end
        end
    end

    // Queue storage needs no reset: every read is gated by count.
    always_ff @(posedge clk_ifu) begin
        if (ret && !pc_load) begin
            queue[tail_idx] <= mem_data;
        end
    end

    assign mbr1_valid = (count != CW'(0));
    assign mbr2_valid = (count >= CW'(2));
    assign mbr1       = mbr1_valid ? queue[head] : 8'h00;
    assign mbr2       = mbr2_valid ? {queue[head], queue[head1_idx]} :
                        (mbr1_valid ? {queue[head], 8'h00} : 16'h0000);
    assign pc_out     = pc;

endmodule

// File: tb/tb_mic_ifu_prefetch.sv
// tb/tb_mic_ifu_prefetch.sv - directed self-checking bench for mic_ifu_prefetch
module tb_mic_ifu_prefetch;

    logic        clk;
    logic        rst_n;
    logic        pc_load;
    logic [31:0] pc_new;
    logic        consume1;
    logic        consume2;
    logic [31:0] mem_addr;
    logic        mem_fetch;
    logic [7:0]  mem_data;
    logic [7:0]  mbr1;
    logic [15:0] mbr2;
    logic        mbr1_valid;
    logic        mbr2_valid;
    logic [31:0] pc_out;
    logic        ifu_err;

    int tests = 0;
    int fails = 0;

    mic_ifu_prefetch #(.DEPTH(6), .AW(32)) dut (
        .clk_ifu    (clk),
        .reset_ifu_n(rst_n),
        .pc_load    (pc_load),
        .pc_new     (pc_new),
        .consume1   (consume1),
        .consume2   (consume2),
        .mem_addr   (mem_addr),
        .mem_fetch  (mem_fetch),
        .mem_data   (mem_data),
        .mbr1       (mbr1),
        .mbr2       (mbr2),
        .mbr1_valid (mbr1_valid),
        .mbr2_valid (mbr2_valid),
        .pc_out     (pc_out),
        .ifu_err    (ifu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: 00,1A,2B,3C,4D,... (low address byte * 0x11 + 9, address 0 holds 00)
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] v;
        v = a[7:0] * 8'h11 + 8'h09;
        return (a[7:0] == 8'h00) ? 8'h00 : v;
    endfunction

    initial mem_data = 8'h00;
    always @(posedge clk) begin
        if (mem_fetch) mem_data <= mem_byte(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; pc_load = 1'b0; pc_new = '0; consume1 = 1'b0; consume2 = 1'b0;
        #2;
        check("rst_fetch", mem_fetch, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_mbr1", mbr1, 0);
        check("rst_mbr2", mbr2, 0);
        check("rst_v1", mbr1_valid, 0);
        check("rst_v2", mbr2_valid, 0);
        check("rst_pc", pc_out, 0);
        check("rst_err", ifu_err, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;

        // Fill from reset: addresses 0..5, then stall
        for (int i = 0; i < 6; i++) begin
            check("fill_fetch", mem_fetch, 1);
            check("fill_addr", mem_addr, i);
            check("fill_v1", mbr1_valid, (i >= 2) ? 1 : 0);
            tick();
        end
        check("full_fetch_a", mem_fetch, 0);
        tick();
        check("full_fetch_b", mem_fetch, 0);
        check("full_v2", mbr2_valid, 1);
        check("full_mbr2", mbr2, 16'h001A);
        check("full_pc", pc_out, 0);
        tick();
        tick();
        check("full_fetch_c", mem_fetch, 0);

        // consume2 from full
        consume2 = 1'b1;
        tick();
        consume2 = 1'b0;
        #1;
        check("c2_pc", pc_out, 2);
        check("c2_mbr1", mbr1, 8'h2B);
        check("c2_mbr2", mbr2, 16'h2B3C);
        check("c2_fetch", mem_fetch, 1);
        check("c2_addr", mem_addr, 6);
        tick();
        check("c2_addr7", mem_addr, 7);
        check("c2_fetch7", mem_fetch, 1);
        tick();
        check("c2_refull", mem_fetch, 0);
        tick();

        // Both consumes together: error, no pop
        consume1 = 1'b1; consume2 = 1'b1;
        tick();
        consume1 = 1'b0; consume2 = 1'b0;
        #1;
        check("both_err", ifu_err, 1);
        check("both_pc", pc_out, 2);
        check("both_mbr2", mbr2, 16'h2B3C);
        check("both_fetch", mem_fetch, 0);

        // Redirect while a fetch is in flight
        consume2 = 1'b1;
        tick();
        consume2 = 1'b0;
        #1;
        check("pre_addr8", mem_addr, 8);
        check("pre_pc4", pc_out, 4);
        tick();
        check("pre_fetch9", mem_fetch, 1);
        check("pre_addr9", mem_addr, 9);
        pc_load = 1'b1; pc_new = 32'h20;
        #1;
        check("redir_nofetch", mem_fetch, 0);
        tick();
        pc_load = 1'b0;
        #1;
        check("redir_pc", pc_out, 32'h20);
        check("redir_v1_a", mbr1_valid, 0);
        check("redir_fetch", mem_fetch, 1);
        check("redir_addr", mem_addr, 32'h20);
        tick();
        check("redir_v1_b", mbr1_valid, 0);
        check("redir_addr21", mem_addr, 32'h21);
        tick();
        check("redir_v1_c", mbr1_valid, 1);
        check("redir_mbr1", mbr1, 8'h29);
        check("redir_v2", mbr2_valid, 0);

        // consume2 with a single byte queued: no pop
        consume2 = 1'b1;
        tick();
        consume2 = 1'b0;
        #1;
        check("c2one_pc", pc_out, 32'h20);
        check("c2one_mbr1", mbr1, 8'h29);
        check("c2one_mbr2", mbr2, 16'h293A);

        // Refill, then consume1 every cycle
        repeat (8) tick();
        check("refill_fetch", mem_fetch, 0);
        check("refill_v2", mbr2_valid, 1);
        consume1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("stream_pc", pc_out, 32'h21 + k);
            check("stream_mbr1", mbr1, mem_byte(32'h21 + k));
            check("stream_v1", mbr1_valid, 1);
        end

        // Asynchronous reset mid-stream
        #1 rst_n = 1'b0;
        #1;
        check("arst_mbr1", mbr1, 0);
        check("arst_mbr2", mbr2, 0);
        check("arst_v1", mbr1_valid, 0);
        check("arst_v2", mbr2_valid, 0);
        check("arst_fetch", mem_fetch, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_pc", pc_out, 0);
        check("arst_err", ifu_err, 0);
        consume1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        consume1 = 1'b1;
        #1;
        check("post_fetch", mem_fetch, 1);
        check("post_addr", mem_addr, 0);
        tick();
        consume1 = 1'b0;
        #1;
        check("empty_c1_err", ifu_err, 1);
        check("empty_c1_pc", pc_out, 0);
        check("empty_c1_v1", mbr1_valid, 0);

        // Address wrap
        pc_load = 1'b1; pc_new = 32'hFFFF_FFFE;
        tick();
        pc_load = 1'b0;
        #1;
        check("wrap_addr0", mem_addr, 32'hFFFF_FFFE);
        check("wrap_fetch", mem_fetch, 1);
        check("wrap_pc", pc_out, 32'hFFFF_FFFE);
        tick();
        check("wrap_addr1", mem_addr, 32'hFFFF_FFFF);
        tick();
        check("wrap_addr2", mem_addr, 32'h0000_0000);
        check("wrap_v1", mbr1_valid, 1);
        check("wrap_mbr1", mbr1, 8'hE7);
        tick();
        check("wrap_addr3", mem_addr, 32'h0000_0001);
        check("wrap_mbr2", mbr2, 16'hE7F8);
        consume2 = 1'b1;
        tick();
        consume2 = 1'b0;
        #1;
        check("wrap_pc0", pc_out, 32'h0);
        check("wrap_v1_after", mbr1_valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
